// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment driver: latches DIGITS nibbles and points and scans them with active-low strobes.
// Optional leading-zero suppression when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     points,
    input  logic                  load,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  p,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);
    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] STROBE0  = DIGITS'(1'b1);

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] latch_data_q, latch_data_d;
    logic [DIGITS-1:0]   latch_pts_q, latch_pts_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                p_q, p_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;
    logic                slot_end_s;
    logic                suppress_s;
    logic [3:0]          nib_s;
    logic                pt_s;
    logic [DIGITS-1:0]   strobe_s;
`ifdef SEG_LZ_BLANK_EN
    logic                above_zero_s;
    logic [DIGITS-1:0]   lz_vec_s;
`endif

    // Latch, scan divider and digit index next state
    always_comb begin
        latch_data_d = latch_data_q;
        latch_pts_d  = latch_pts_q;
        div_d        = div_q;
        idx_d        = idx_q;
        if (load) begin
            latch_data_d = data;
            latch_pts_d  = points;
        end else begin
            latch_data_d = latch_data_q;
            latch_pts_d  = latch_pts_q;
        end
        slot_end_s = (div_q == DIV_LAST);
        if (slot_end_s) begin
            div_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            div_d = div_q + CNT_W'(1);
            idx_d = idx_q;
        end
        frame_done_d = slot_end_s && (idx_q == IDX_LAST);
    end

    // Display output next state from the current digit, pre-load latch contents and live masks
    always_comb begin
        seg_d    = 7'h7F;
        p_d      = 1'b1;
        an_d     = '1;
        nib_s    = latch_data_q[{idx_q, 2'b00} +: 4];
        pt_s     = latch_pts_q[idx_q];
        strobe_s = ~(STROBE0 << idx_q);
`ifdef SEG_LZ_BLANK_EN
        // A digit is a leading zero when it and every higher digit hold zero; digit 0 always shows
        above_zero_s = 1'b1;
        lz_vec_s     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above_zero_s = above_zero_s && (latch_data_q[4*k +: 4] == 4'h0);
            lz_vec_s[k]  = above_zero_s && (k != 0);
        end
        suppress_s = lz_vec_s[idx_q];
`else
        suppress_s = 1'b0;
`endif
        if (blank || !digit_en[idx_q]) begin
            seg_d = 7'h7F;
            p_d   = 1'b1;
            an_d  = '1;
        end else if (suppress_s) begin
            if (pt_s) begin
                an_d = strobe_s;
                p_d  = 1'b0;
            end else begin
                an_d = '1;
                p_d  = 1'b1;
            end
        end else begin
            an_d  = strobe_s;
            seg_d = hex_decode(nib_s);
            p_d   = ~pt_s;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_data_q <= '0;
            latch_pts_q  <= '0;
            div_q        <= '0;
            idx_q        <= '0;
            seg_q        <= 7'h7F;
            p_q          <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            latch_data_q <= latch_data_d;
            latch_pts_q  <= latch_pts_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            p_q          <= p_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign p          = p_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  points;
    logic        load;
    logic [3:0]  digit_en;
    logic        blank;
    logic [6:0]  seg;
    logic        p;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] dec [16];
    logic [6:0] sseg [4];
    logic [15:0] cdata;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .data(data), .points(points), .load(load),
        .digit_en(digit_en), .blank(blank), .seg(seg), .p(p), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Digit whose output is visible after edge number cyc since reset release
    function automatic int oidx();
        return ((cyc - 1) / 4) % 4;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_lit(input string tag, input int i, input logic [6:0] s);
        logic [3:0] st;
        st = 4'b0001 << i;
        check({tag, "_an"}, {4'h0, an}, {4'h0, ~st});
        check({tag, "_seg"}, {1'b0, seg}, {1'b0, s});
    endtask

    task automatic chk_dark(input string tag);
        check({tag, "_an"}, {4'h0, an}, 8'h0F);
        check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        check({tag, "_p"}, {7'h00, p}, 8'h01);
    endtask

    initial begin
        dec[0]  = 7'b1000000; dec[1]  = 7'b1111001; dec[2]  = 7'b0100100; dec[3]  = 7'b0110000;
        dec[4]  = 7'b0011001; dec[5]  = 7'b0010010; dec[6]  = 7'b0000010; dec[7]  = 7'b1111000;
        dec[8]  = 7'b0000000; dec[9]  = 7'b0010000; dec[10] = 7'b0001000; dec[11] = 7'b0000011;
        dec[12] = 7'b1000110; dec[13] = 7'b0100001; dec[14] = 7'b0000110; dec[15] = 7'b0001110;
        sseg[0] = 7'b1111001; sseg[1] = 7'b1111000; sseg[2] = 7'b0001000; sseg[3] = 7'b0110000;

        rst = 1'b1; data = 16'h0000; points = 4'b0000; load = 1'b0;
        digit_en = 4'hF; blank = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        repeat (6) step();
        chk_lit("prerst", 1, dec[0]);

        // Asynchronous reset between edges: outputs dark without waiting for a clock
        #2 rst = 1'b1;
        #1;
        chk_dark("rst");
        check("rst_fd", {7'h00, frame_done}, 8'h00);

        @(negedge clk);
        data = 16'h3A71; points = 4'b0100; load = 1'b1; rst = 1'b0;
        cyc = 0;
        step();
        load = 1'b0;
        chk_lit("rst_first", 0, dec[0]);

        for (int k = 0; k < 16; k++) begin
            step();
            chk_lit("scan", oidx(), sseg[oidx()]);
            check("scan_p", {7'h00, p}, (oidx() == 2) ? 8'h00 : 8'h01);
            check("scan_fd", {7'h00, frame_done}, (cyc % 16 == 0) ? 8'h01 : 8'h00);
        end

        points = 4'b0000;
        for (int n = 0; n < 16; n++) begin
            logic [3:0] nib;
            nib = n[3:0];
            data = {4{nib}};
            load = 1'b1;
            step();
            load = 1'b0;
            step();
            chk_lit("decode", oidx(), dec[n]);
        end

        digit_en = 4'b1010;
        for (int k = 0; k < 16; k++) begin
            step();
            if (digit_en[oidx()]) begin
                chk_lit("mask_on", oidx(), dec[15]);
            end else begin
                chk_dark("mask_off");
            end
        end

        digit_en = 4'hF;
        blank = 1'b1;
        repeat (8) begin
            step();
            chk_dark("blank");
        end
        blank = 1'b0;
        step();
        chk_lit("unblank", oidx(), dec[15]);

        // Load on the edge that advances the digit index
        while (cyc % 4 != 3) step();
        cdata = 16'h4C2E;
        data = cdata;
        load = 1'b1;
        step();
        load = 1'b0;
        chk_lit("coll_old", oidx(), dec[15]);
        step();
        chk_lit("coll_new", oidx(), dec[cdata[4*oidx() +: 4]]);

        data = 16'h0050;
        points = 4'b0000;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            case (oidx())
`ifdef SEG_LZ_BLANK_EN
                3, 2:    chk_dark("lz_hi");
`else
                3, 2:    chk_lit("lz_hi", oidx(), dec[0]);
`endif
                1:       chk_lit("lz_d1", 1, dec[5]);
                default: chk_lit("lz_d0", 0, dec[0]);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
